calc_op_fsm: RTL and testbench

Parametrised keypad-driven calculator controller: accepts decoded key strobes, builds two decimal operands, applies add/sub (optionally multiply) on equals or on a chained operator, and drives a signed display value. Sits between the keypad decoder and the display driver. Successor to the single-operation controller: generic width and digit count, operator chaining, result reuse and overflow/error handling.

---
 rtl/calc_op_fsm.sv | 180 ++++++++++++++++++
 tb/tb_calc_op_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_fsm.sv
// Keypad calculator controller: builds two decimal operands, applies add/sub on '=' or on a
// chained operator, and flags overflow. Define CALC_MUL_EN to add the multiply key (0xD).
module calc_op_fsm #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic signed [WIDTH-1:0] display,
    output logic [1:0]              op_pending,
    output logic                    result_valid,
    output logic                    err,
    output logic [2:0]              state_dbg
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAXD = CW'(MAX_DIGITS);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'b000,
        S_OP_WAIT = 3'b001,
        S_ENTER_B = 3'b010,
        S_RESULT  = 3'b011,
        S_ERROR   = 3'b100
    } state_t;

    state_t                   state_q;
    logic signed [WIDTH-1:0]  a_q, b_q, disp_q;
    logic [CW-1:0]            acnt_q, bcnt_q;
    logic [1:0]               op_q;
    logic                     rv_q, err_q;

    logic                     key_digit, key_op, key_eq, key_clr;
    logic [1:0]               key_opc;
    logic [WIDTH-1:0]         digit_ext;
    logic signed [WIDTH-1:0]  a_dig_d, b_dig_d, calc_res_d;
    logic [2*WIDTH-1:0]       a_ext, b_ext, calc_full;
    logic                     calc_ovf_d;

    always_comb begin
        key_digit = (key_code <= 4'd9);
        key_eq    = (key_code == 4'hE);
        key_clr   = (key_code == 4'hC);
        key_op    = 1'b0;
        key_opc   = 2'b00;
        case (key_code)
            4'hA: begin key_op = 1'b1; key_opc = 2'b01; end
            4'hB: begin key_op = 1'b1; key_opc = 2'b10; end
`ifdef CALC_MUL_EN
            4'hD: begin key_op = 1'b1; key_opc = 2'b11; end
`endif
            default: ;
        endcase
    end

    // x*10 + digit as shifts; operands under entry are never negative
    assign digit_ext = {{(WIDTH-4){1'b0}}, key_code};
    assign a_dig_d   = (a_q << 3) + (a_q << 1) + digit_ext;
    assign b_dig_d   = (b_q << 3) + (b_q << 1) + digit_ext;

    always_comb begin
        a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext     = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        calc_full = a_ext;
        case (op_q)
            2'b01: calc_full = a_ext + b_ext;
            2'b10: calc_full = a_ext - b_ext;
`ifdef CALC_MUL_EN
            2'b11: calc_full = a_ext * b_ext;
`endif
            default: calc_full = a_ext;
        endcase
    end

    // In range only if every bit above the WIDTH-1 sign position matches the sign
    assign calc_ovf_d = !((&calc_full[2*WIDTH-1:WIDTH-1]) || !(|calc_full[2*WIDTH-1:WIDTH-1]));
    assign calc_res_d = calc_full[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            acnt_q  <= '0;
            bcnt_q  <= '0;
            op_q    <= 2'b00;
            disp_q  <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (key_valid) begin
                if (key_clr) begin
                    state_q <= S_ENTER_A;
                    a_q     <= '0;
                    b_q     <= '0;
                    acnt_q  <= '0;
                    bcnt_q  <= '0;
                    op_q    <= 2'b00;
                    disp_q  <= '0;
                    err_q   <= 1'b0;
                end else begin
                    case (state_q)
                        S_ENTER_A: begin
                            if (key_digit && acnt_q < MAXD) begin
                                a_q    <= a_dig_d;
                                acnt_q <= acnt_q + CW'(1);
                                disp_q <= a_dig_d;
                            end else if (key_op) begin
                                op_q    <= key_opc;
                                state_q <= S_OP_WAIT;
                                disp_q  <= a_q;
                            end else if (key_eq) begin
                                disp_q <= a_q;
                            end
                        end
                        S_OP_WAIT: begin
                            if (key_digit) begin
                                b_q     <= digit_ext;
                                bcnt_q  <= CW'(1);
                                state_q <= S_ENTER_B;
                                disp_q  <= digit_ext;
                            end else if (key_op) begin
                                op_q <= key_opc;
                            end
                        end
                        S_ENTER_B, S_RESULT: begin
                            if (key_digit && state_q == S_ENTER_B) begin
                                if (bcnt_q < MAXD) begin
                                    b_q    <= b_dig_d;
                                    bcnt_q <= bcnt_q + CW'(1);
                                    disp_q <= b_dig_d;
                                end
                            end else if (key_digit) begin
                                // fresh calculation starting from the result screen
                                a_q     <= digit_ext;
                                acnt_q  <= CW'(1);
                                b_q     <= '0;
                                bcnt_q  <= '0;
                                op_q    <= 2'b00;
                                state_q <= S_ENTER_A;
                                disp_q  <= digit_ext;
                            end else if (key_op && state_q == S_RESULT) begin
                                op_q    <= key_opc;
                                state_q <= S_OP_WAIT;
                                disp_q  <= a_q;
                            end else if (key_eq || key_op) begin
                                if (calc_ovf_d) begin
                                    state_q <= S_ERROR;
                                    disp_q  <= '0;
                                    err_q   <= 1'b1;
                                end else begin
                                    a_q     <= calc_res_d;
                                    disp_q  <= calc_res_d;
                                    rv_q    <= 1'b1;
                                    if (key_eq) begin
                                        state_q <= S_RESULT;
                                    end else begin
                                        op_q    <= key_opc;
                                        state_q <= S_OP_WAIT;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign display      = disp_q;
    assign op_pending   = op_q;
    assign result_valid = rv_q;
    assign err          = err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_calc_op_fsm.sv
// Self-checking bench for calc_op_fsm: directed calculator scenarios plus random key streams
// compared every cycle against an integer reference model of the calculator.
module tb_calc_op_fsm;

    localparam int WIDTH = 16;
    localparam int MAXD  = 4;
`ifdef CALC_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif
    localparam longint VMAX = (64'sd1 <<< (WIDTH-1)) - 1;
    localparam longint VMIN = -(64'sd1 <<< (WIDTH-1));

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    key_valid = 1'b0;
    logic [3:0]              key_code = 4'h0;
    logic signed [WIDTH-1:0] display;
    logic [1:0]              op_pending;
    logic                    result_valid;
    logic                    err;
    logic [2:0]              state_dbg;

    calc_op_fsm #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .display(display), .op_pending(op_pending), .result_valid(result_valid),
        .err(err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model: mode 0 entering A, 1 waiting for B, 2 entering B, 3 showing result, 4 error
    int     m_mode, m_na, m_nb, m_op;
    longint m_a, m_b, m_disp;
    bit     m_rv, m_err;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_na = 0; m_nb = 0; m_op = 0;
        m_a = 0; m_b = 0; m_disp = 0; m_rv = 0; m_err = 0;
    endfunction

    function automatic void model_compute(input bit chain, input int new_op);
        longint r;
        case (m_op)
            1: r = m_a + m_b;
            2: r = m_a - m_b;
            3: r = m_a * m_b;
            default: r = m_a;
        endcase
        if (r > VMAX || r < VMIN) begin
            m_mode = 4; m_disp = 0; m_err = 1;
        end else begin
            m_a = r; m_disp = r; m_rv = 1;
            if (chain) begin m_op = new_op; m_mode = 1; end
            else m_mode = 3;
        end
    endfunction

    function automatic void model_key(input int k);
        int opc;
        m_rv = 0;
        opc = (k == 10) ? 1 : (k == 11) ? 2 : (k == 13 && MUL) ? 3 : 0;
        if (k == 12) begin
            model_reset();
        end else if (m_mode == 4) begin
        end else if (k <= 9) begin
            case (m_mode)
                0: if (m_na < MAXD) begin m_a = m_a * 10 + k; m_na++; m_disp = m_a; end
                1: begin m_b = k; m_nb = 1; m_mode = 2; m_disp = m_b; end
                2: if (m_nb < MAXD) begin m_b = m_b * 10 + k; m_nb++; m_disp = m_b; end
                default: begin m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_op = 0; m_mode = 0; m_disp = m_a; end
            endcase
        end else if (opc != 0) begin
            case (m_mode)
                0, 3: begin m_op = opc; m_mode = 1; m_disp = m_a; end
                1: m_op = opc;
                default: model_compute(1'b1, opc);
            endcase
        end else if (k == 14) begin
            if (m_mode == 0) m_disp = m_a;
            else if (m_mode >= 2) model_compute(1'b0, 0);
        end
    endfunction

    task automatic press(input int k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'(k);
        @(posedge clk);
        #1;
        model_key(k);
        key_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        m_rv = 0;
    endtask

    task automatic do_reset(input bit with_key);
        @(negedge clk);
        reset = 1'b1;
        key_valid = with_key;
        key_code = 4'h5;
        @(posedge clk);
        #1;
        model_reset();
        chk_en = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            byte c;
            c = s[i];
            case (c)
                "+": press(10);
                "-": press(11);
                "C": press(12);
                "*": press(13);
                "=": press(14);
                default: press(int'(c) - 48);
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("display", longint'(display), m_disp);
            chk("op_pending", longint'(op_pending), longint'(m_op));
            chk("result_valid", longint'(result_valid), longint'(m_rv));
            chk("err", longint'(err), longint'(m_err));
            chk("state_dbg", longint'(state_dbg), longint'(m_mode));
        end
    end

    initial begin
        model_reset();
        do_reset(1'b0);
        chk("reset_display", longint'(display), 0);
        chk("reset_state", longint'(state_dbg), 0);

        keys("12+34=");
        chk("sum46", longint'(display), 46);
        chk("sum46_model", m_disp, 46);
        chk("sum46_rv", longint'(result_valid), 1);
        chk("sum46_state", longint'(state_dbg), 3);
        idle();
        chk("sum46_rv_drop", longint'(result_valid), 0);

        keys("C5-9=");
        chk("diff_m4", longint'(display), -4);
        chk("diff_m4_model", m_disp, -4);
        keys("=");
        chk("repeat_m13", longint'(display), -13);
        chk("repeat_m13_model", m_disp, -13);

        keys("C10+5-");
        chk("chain15", longint'(display), 15);
        chk("chain15_rv", longint'(result_valid), 1);
        keys("3=");
        chk("chain12", longint'(display), 12);
        chk("chain12_model", m_disp, 12);

        keys("C12345");
        chk("digit_limit", longint'(display), 1234);
        chk("digit_limit_model", m_disp, 1234);

        keys("C9999+9999=");
        chk("ovf_step1", longint'(display), 19998);
        keys("+9999=");
        chk("ovf_step2", longint'(display), 29997);
        keys("+9999=");
        chk("ovf_err", longint'(err), 1);
        chk("ovf_display", longint'(display), 0);
        chk("ovf_err_model", longint'(m_err), 1);
        keys("5=+");
        chk("err_ignores_keys", longint'(display), 0);
        keys("C");
        chk("clear_err", longint'(err), 0);
        chk("clear_state", longint'(state_dbg), 0);

        keys("C12*11=");
        chk("mul_key", longint'(display), MUL ? 132 : 1211);
        chk("mul_key_model", m_disp, MUL ? 132 : 1211);

        keys("C123");
        do_reset(1'b1);
        chk("reset_mid_entry", longint'(display), 0);
        chk("reset_mid_state", longint'(state_dbg), 0);

        for (int n = 0; n < 4000; n++) begin
            int r, k;
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = int'($urandom_range(0, 9));
            else if (r < 65) k = 10;
            else if (r < 75) k = 11;
            else if (r < 82) k = 13;
            else if (r < 93) k = 14;
            else if (r < 97) k = 12;
            else             k = 15;
            press(k);
            if ($urandom_range(0, 4) == 0) idle();
            if (n == 2000) do_reset($urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
